// File: rtl/onehot_dispatch_decoder.sv
// One-hot dispatch decoder: buffers one binary target index and drives a held
// one-hot request to that target until it acks or the request times out.
module onehot_dispatch_decoder #(
    parameter  int WIDTH   = 4,
    parameter  int TIMEOUT = 255,
    localparam int IW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    s_index,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_unencoded,
    input  logic [WIDTH-1:0] m_ack,
    output logic             done_valid,
    output logic [IW-1:0]    done_index,
    output logic             done_timeout,
    output logic             done_error,
    output logic             busy
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]    CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [IW:0]      WIDTH_L  = (IW + 1)'(WIDTH);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic             buf_valid_q, buf_valid_d;
    logic [IW-1:0]    buf_index_q, buf_index_d;
    logic [IW-1:0]    active_q,    active_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] req_q,       req_d;
    logic             timeout_q,   timeout_d;
    logic             error_q,     error_d;

    logic accept;
    logic ack_hit;

    assign accept  = s_valid && !buf_valid_q;
    // req_q is one-hot on the active target while in REQ, so masking selects its ack
    assign ack_hit = |(m_ack & req_q);

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_index_d = buf_index_q;
        active_d    = active_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        timeout_d   = timeout_q;
        error_d     = error_q;

        if (accept) begin
            buf_valid_d = 1'b1;
            buf_index_d = s_index;
        end

        case (state_q)
            IDLE: begin
                if (buf_valid_q) begin
                    buf_valid_d = 1'b0;
                    active_d    = buf_index_q;
                    cnt_d       = '0;
                    timeout_d   = 1'b0;
                    if ({1'b0, buf_index_q} < WIDTH_L) begin
                        state_d = REQ;
                        req_d   = ONE << buf_index_q;
                        error_d = 1'b0;
                    end else begin
                        state_d = DONE;
                        error_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (ack_hit) begin
                    state_d   = DONE;
                    req_d     = '0;
                    timeout_d = 1'b0;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    req_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d   = IDLE;
                timeout_d = 1'b0;
                error_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                req_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_index_q <= '0;
            active_q    <= '0;
            cnt_q       <= '0;
            req_q       <= '0;
            timeout_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_index_q <= buf_index_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            timeout_q   <= timeout_d;
            error_q     <= error_d;
        end
    end

    assign s_ready      = !buf_valid_q;
    assign m_unencoded  = req_q;
    assign done_valid   = (state_q == DONE);
    assign done_index   = done_valid ? active_q : '0;
    assign done_timeout = done_valid && timeout_q;
    assign done_error   = done_valid && error_q;
    assign busy         = (state_q != IDLE) || buf_valid_q;

endmodule
